// File: rtl/nanov_store_pkg.sv
// Shared types and helpers for the nanoV store controller: peripheral space
// decode constants, the queued write entry and the CPU data bit-reversal.
package nanov_store_pkg;

  localparam logic [1:0] PERIPH_SPACE = 2'b11;

  localparam logic [1:0] TGT_GPIO  = 2'd0;
  localparam logic [1:0] TGT_UART  = 2'd1;
  localparam logic [1:0] TGT_TIMER = 2'd2;
  localparam logic [1:0] TGT_USER  = 2'd3;

  // Peripheral word addresses sit below the target bits [29:28], so 28 is the widest
  // address a queued entry can carry; narrower WA_W builds zero-extend into this field.
  localparam int ADDR_MAX_W = 28;

  typedef struct packed {
    logic [1:0]            tgt;
    logic [ADDR_MAX_W-1:0] addr;
    logic [31:0]           data;
  } store_entry_t;

  function automatic logic [31:0] bit_rev(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

endpackage

// File: rtl/nanov_store_ctrl_if.sv
// Peripheral write bus: one-hot target select, word address and data, qualified
// by a valid/ready handshake.
interface nanov_store_ctrl_if #(
  parameter int WA_W = 28
);
  logic            wr_valid;
  logic            wr_ready;
  logic [3:0]      wr_sel;
  logic [WA_W-1:0] wr_addr;
  logic [31:0]     wr_data;

  modport master (output wr_valid, wr_sel, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_sel, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/nanov_store_fifo.sv
// Generic synchronous FIFO. Pointers carry an extra wrap bit so full and empty
// are distinguished without a separate counter; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module nanov_store_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nanov_store_ctrl.sv
// nanoV store sequencer: turns CPU address/data strobes into queued, handshaked
// peripheral writes. Define NANOV_STORE_CTRL_TIMEOUT_EN to drop a head entry the
// target has refused for TIMEOUT cycles and expose a sticky timeout flag.
module nanov_store_ctrl
  import nanov_store_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WA_W  = 28
`ifdef NANOV_STORE_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [31:0]         data_out,
  input  logic                store_addr_out,
  input  logic                store_data_out,
  output logic                cpu_stall,
  nanov_store_ctrl_if.master  wr,
  output logic                overflow,
  output logic [7:0]          drop_count,
  input  logic                clr_status
`ifdef NANOV_STORE_CTRL_TIMEOUT_EN
  , output logic              timeout
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

  logic [31:0]   held_addr;
  logic          push_req;
  logic          push_ok;
  logic          pop_req;
  logic          handshake;
  logic          ovf_drop;
  logic          drop_ev;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  store_entry_t  push_entry;
  store_entry_t  head;

  assign handshake = wr.wr_valid && wr.wr_ready;

`ifdef NANOV_STORE_CTRL_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt;
  logic       tmo_hit;

  // The pop lands on the edge where the stalled-cycle count would reach TIMEOUT.
  assign tmo_hit = wr.wr_valid && !wr.wr_ready && (tmo_cnt == TMO_LAST);
  assign pop_req = handshake || tmo_hit;
  assign drop_ev = ovf_drop || tmo_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         tmo_cnt <= '0;
    else if (!wr.wr_valid || pop_req)  tmo_cnt <= '0;
    else                               tmo_cnt <= tmo_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           timeout <= 1'b0;
    else if (clr_status) timeout <= 1'b0;
    else if (tmo_hit)    timeout <= 1'b1;
  end
`else
  assign pop_req = handshake;
  assign drop_ev = ovf_drop;
`endif

  // Stores outside peripheral space belong to the SPI memory path and are not queued.
  assign push_req   = store_data_out && (held_addr[31:30] == PERIPH_SPACE);
  assign push_ok    = push_req && (!full || pop_req);
  assign ovf_drop   = push_req && full && !pop_req;
  assign count_next = count + CW'(push_ok) - CW'(pop_req);

  always_comb begin
    push_entry.tgt  = held_addr[29:28];
    push_entry.addr = ADDR_MAX_W'(held_addr[WA_W-1:0]);
    push_entry.data = bit_rev(data_out);
  end

  // A coincident address strobe wins: the data strobe has already used the old value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               held_addr <= '0;
    else if (store_addr_out) held_addr <= data_out;
    else if (store_data_out) held_addr <= held_addr + 32'd4;
  end

  nanov_store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(store_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .wdata (push_entry),
    .pop   (pop_req),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cpu_stall <= 1'b0;
    else       cpu_stall <= (count_next >= STALL_LVL);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr_status) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop_ev) begin
      if (ovf_drop)             overflow   <= 1'b1;
      if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
    end
  end

  assign wr.wr_valid = !empty;
  assign wr.wr_addr  = wr.wr_valid ? head.addr[WA_W-1:0] : '0;
  assign wr.wr_data  = wr.wr_valid ? head.data : '0;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    wr.wr_sel = 4'b0000;
    if (wr.wr_valid) begin
      case (head.tgt)
        TGT_GPIO:  wr.wr_sel = 4'b0001;
        TGT_UART:  wr.wr_sel = 4'b0010;
        TGT_TIMER: wr.wr_sel = 4'b0100;
        TGT_USER:  wr.wr_sel = 4'b1000;
        default:   wr.wr_sel = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_nanov_store_ctrl.sv
// Scoreboard bench for nanov_store_ctrl: directed stores push hand-computed
// expected writes; a negedge monitor compares every accepted handshake.
module tb_nanov_store_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] data_out;
  logic        store_addr_out;
  logic        store_data_out;
  logic        cpu_stall;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        clr_status;
`ifdef NANOV_STORE_CTRL_TIMEOUT_EN
  logic        timeout;
`endif

  nanov_store_ctrl_if #(.WA_W(28)) wr_if ();

  nanov_store_ctrl #(.DEPTH(4), .WA_W(28)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .data_out       (data_out),
    .store_addr_out (store_addr_out),
    .store_data_out (store_data_out),
    .cpu_stall      (cpu_stall),
    .wr             (wr_if),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clr_status     (clr_status)
`ifdef NANOV_STORE_CTRL_TIMEOUT_EN
    , .timeout      (timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [27:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstn === 1'b1 && wr_if.wr_valid === 1'b1 && wr_if.wr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got sel=%b addr=0x%07h data=0x%08h expected none",
                 wr_if.wr_sel, wr_if.wr_addr, wr_if.wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_sel",  32'(wr_if.wr_sel),  32'(e.sel));
        check("wr_addr", 32'(wr_if.wr_addr), 32'(e.addr));
        check("wr_data", wr_if.wr_data,      e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_strobe(input logic [31:0] a);
    data_out       = a;
    store_addr_out = 1'b1;
    tick();
    store_addr_out = 1'b0;
  endtask

  task automatic data_strobe(input logic [31:0] d);
    data_out       = d;
    store_data_out = 1'b1;
    tick();
    store_data_out = 1'b0;
  endtask

  task automatic expect_write(input logic [3:0] sel, input logic [27:0] addr, input logic [31:0] data);
    exp_t e;
    e.sel  = sel;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  initial begin
    rstn            = 1'b0;
    data_out        = '0;
    store_addr_out  = 1'b0;
    store_data_out  = 1'b0;
    clr_status      = 1'b0;
    wr_if.wr_ready  = 1'b0;

    #12;
    check("rst_wr_valid",   32'(wr_if.wr_valid), 32'd0);
    check("rst_wr_sel",     32'(wr_if.wr_sel),   32'd0);
    check("rst_wr_addr",    32'(wr_if.wr_addr),  32'd0);
    check("rst_wr_data",    wr_if.wr_data,       32'd0);
    check("rst_cpu_stall",  32'(cpu_stall),      32'd0);
    check("rst_overflow",   32'(overflow),       32'd0);
    check("rst_drop_count", 32'(drop_count),     32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single store to the UART target, one-cycle latency.
    addr_strobe(32'hD000_0010);
    expect_write(4'b0010, 28'h000_0010, 32'h8000_0000);
    data_strobe(32'h0000_0001);
    check("single_valid", 32'(wr_if.wr_valid), 32'd1);
    check("single_sel",   32'(wr_if.wr_sel),   32'h2);
    wr_if.wr_ready = 1'b1;
    tick();
    wr_if.wr_ready = 1'b0;
    check("single_drained", 32'(wr_if.wr_valid), 32'd0);

    // Burst of three with the target stalled, then drained in order.
    addr_strobe(32'hC000_0000);
    expect_write(4'b0001, 28'h000_0000, 32'h4000_0000);
    data_strobe(32'h0000_0002);
    expect_write(4'b0001, 28'h000_0004, 32'hC000_0000);
    data_strobe(32'h0000_0003);
    check("burst_stall_at_2", 32'(cpu_stall), 32'd0);
    expect_write(4'b0001, 28'h000_0008, 32'h0000_0001);
    data_strobe(32'h8000_0000);
    check("burst_stall_at_3", 32'(cpu_stall), 32'd1);
    wr_if.wr_ready = 1'b1;
    tick();
    tick();
    check("burst_valid_after_2", 32'(wr_if.wr_valid), 32'd1);
    tick();
    check("burst_valid_after_3", 32'(wr_if.wr_valid), 32'd0);
    check("burst_stall_drained", 32'(cpu_stall),      32'd0);
    wr_if.wr_ready = 1'b0;

    // Overflow: fifth store into a full FIFO is dropped.
    addr_strobe(32'hC000_0100);
    expect_write(4'b0001, 28'h000_0100, 32'h8000_0000);
    data_strobe(32'h0000_0001);
    expect_write(4'b0001, 28'h000_0104, 32'h4000_0000);
    data_strobe(32'h0000_0002);
    expect_write(4'b0001, 28'h000_0108, 32'hC000_0000);
    data_strobe(32'h0000_0003);
    expect_write(4'b0001, 28'h000_010C, 32'hF000_0000);
    data_strobe(32'h0000_000F);
    data_strobe(32'hFFFF_0000);
    check("ovf_flag",  32'(overflow),   32'd1);
    check("ovf_count", 32'(drop_count), 32'd1);
    check("ovf_stall", 32'(cpu_stall),  32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_flag",  32'(overflow),   32'd0);
    check("clr_count", 32'(drop_count), 32'd0);

    // Clear coincident with a drop: clear wins (store at 0x114 is lost).
    clr_status = 1'b1;
    data_strobe(32'hFFFF_0000);
    clr_status = 1'b0;
    check("clr_vs_drop_flag",  32'(overflow),   32'd0);
    check("clr_vs_drop_count", 32'(drop_count), 32'd0);

    // Full FIFO with a same-cycle pop accepts the push.
    wr_if.wr_ready = 1'b1;
    expect_write(4'b0001, 28'h000_0118, 32'h0000_8000);
    data_strobe(32'h0001_0000);
    check("full_pop_push_flag",  32'(overflow),   32'd0);
    check("full_pop_push_count", 32'(drop_count), 32'd0);
    check("full_pop_push_stall", 32'(cpu_stall),  32'd1);
    repeat (4) tick();
    check("ovf_drained", 32'(wr_if.wr_valid), 32'd0);
    wr_if.wr_ready = 1'b0;

    // Non-peripheral store ignored, then a GPIO store.
    addr_strobe(32'h0000_1000);
    data_strobe(32'h0000_0001);
    check("nonperiph_valid", 32'(wr_if.wr_valid), 32'd0);
    tick();
    check("nonperiph_valid_later", 32'(wr_if.wr_valid), 32'd0);
    addr_strobe(32'hC000_0000);
    expect_write(4'b0001, 28'h000_0000, 32'h8000_0000);
    data_strobe(32'h0000_0001);
    check("gpio_valid", 32'(wr_if.wr_valid), 32'd1);
    wr_if.wr_ready = 1'b1;
    tick();
    wr_if.wr_ready = 1'b0;

    // Simultaneous strobes: data uses the old address, the new one loads unincremented.
    addr_strobe(32'hC000_0020);
    expect_write(4'b0001, 28'h000_0020, 32'h0000_0007);
    data_out       = 32'hE000_0000;
    store_addr_out = 1'b1;
    store_data_out = 1'b1;
    tick();
    store_addr_out = 1'b0;
    store_data_out = 1'b0;
    expect_write(4'b0100, 28'h000_0000, 32'h8000_0000);
    data_strobe(32'h0000_0001);
    wr_if.wr_ready = 1'b1;
    tick();
    tick();
    wr_if.wr_ready = 1'b0;
    check("simul_drained", 32'(wr_if.wr_valid), 32'd0);

    // Asynchronous reset with two queued entries discards them.
    addr_strobe(32'hC000_0000);
    data_strobe(32'h0000_0001);
    data_strobe(32'h0000_0002);
    check("prerst_valid", 32'(wr_if.wr_valid), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_valid", 32'(wr_if.wr_valid), 32'd0);
    check("midrst_sel",   32'(wr_if.wr_sel),   32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("postrst_valid", 32'(wr_if.wr_valid), 32'd0);
    wr_if.wr_ready = 1'b1;
    tick();
    tick();
    check("postrst_empty", 32'(wr_if.wr_valid), 32'd0);
    // held_addr is back to 0, outside peripheral space.
    data_strobe(32'h0000_0001);
    check("postrst_held_cleared", 32'(wr_if.wr_valid), 32'd0);
    wr_if.wr_ready = 1'b0;

`ifdef NANOV_STORE_CTRL_TIMEOUT_EN
    addr_strobe(32'hC000_0000);
    data_strobe(32'h0000_0001);
    check("tmo_valid_start", 32'(wr_if.wr_valid), 32'd1);
    repeat (254) tick();
    check("tmo_valid_before", 32'(wr_if.wr_valid), 32'd1);
    check("tmo_flag_before",  32'(timeout),        32'd0);
    tick();
    check("tmo_valid_after", 32'(wr_if.wr_valid), 32'd0);
    check("tmo_flag",        32'(timeout),        32'd1);
    check("tmo_drop_count",  32'(drop_count),     32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("tmo_clr", 32'(timeout), 32'd0);
`endif

    tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
